param_rf_mp: RTL and testbench
==============================

// Module: param_rf_mp
// PURPOSE
//  Parametrised multi-port register file: NWR write ports, NRD read ports, registered read data.
//  Write-first forwarding on every read port. Built-in clear engine zeroes storage after reset or on request.
//  Drop-in successor to the single-port block RF in the yosys/LiveHD regression set.
//  Used as the generic storage primitive for block-RAM inference tests.
// PARAMETERS
//  WIDTH      13  data bits per entry
//  DEPTH      16  number of entries (>=2)
//  ADDR_BITS  7   address port width; may exceed clog2(DEPTH)
//  NWR        2   write ports (>=1)
//  NRD        2   read ports (>=1)
// PORTS
//  clk      in   1               clock, all state on posedge
//  reset_n  in   1               asynchronous, active-low reset
//  we       in   NWR             per-port write enable
//  waddr    in   NWR*ADDR_BITS   write addresses, port i at [i*ADDR_BITS +: ADDR_BITS]
//  din      in   NWR*WIDTH       write data, port i at [i*WIDTH +: WIDTH]
//  raddr    in   NRD*ADDR_BITS   read addresses, packed as waddr
//  q        out  NRD*WIDTH       registered read data, packed as din
//  clr      in   1               request full-array clear (level, sampled when idle)
//  busy     out  1               clear engine active; array unusable
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - q=0, busy=1, clear pointer=0, FSM=CLEAR.
//   - Array contents not reset directly.
//  FSM:
//   - CLEAR: writes 0 to entry ptr each cycle; ptr++.
//   - After writing entry DEPTH-1, goes IDLE next edge, busy=0.
//   - A clear takes exactly DEPTH cycles.
//   - IDLE: clr=1 at a posedge -> CLEAR, ptr=0, busy=1 from next cycle.
//   - clr is ignored while already in CLEAR; no restart.
//  Writes (IDLE only):
//   - we[i]=1 with waddr[i]<DEPTH -> entry written at posedge.
//   - waddr[i]>=DEPTH: write dropped silently (no aliasing/wrap).
//   - Same-cycle, same-address writes: highest-index port wins.
//   - While busy=1, all we are ignored.
//  Reads (latency 1):
//   - q[j] at cycle n+1 reflects raddr[j] at cycle n.
//   - raddr[j]>=DEPTH -> q[j]=0.
//   - Forwarding: if any enabled, in-range write port hits raddr[j] in the same cycle,
//     q[j] takes that din (highest-index port on multi-hit), not old contents.
//   - While busy=1 (including the cycle clr is accepted), q[j] loads 0.
//  q holds value every cycle it is loaded; no read enable; no X ever driven post-reset.
//  reset_n asserted mid-clear: pointer returns to 0; full clear restarts on deassertion.
// TESTING
//  1. Reset, DEPTH=16
//     -> busy=1 for exactly 16 cycles after reset_n rises, then 0.
//     -> every read returns 0 afterwards.
//  2. Port0 writes addr3=0x0ABC; next cycle port1 reads addr3
//     -> q[1]=0x0ABC one cycle later.
//  3. Same cycle: we0 addr5=0x111, raddr0=5
//     -> q[0]=0x111 next cycle (forwarding).
//     -> a later read of addr5 still returns 0x111.
//  4. Same cycle: we0 addr7=0x001, we1 addr7=0x1FF
//     -> forwarded q=0x1FF; later read of addr7 =0x1FF.
//  5. Write addr 16 and addr 127 with 0x1234
//     -> no entry changes (scan all 16).
//     -> raddr=100 returns 0.
//  6. Fill array, pulse clr for 1 cycle, then attempt write addr2 during busy
//     -> busy=1 for 16 cycles, all entries 0, write dropped.
//     -> reset_n pulsed at cycle 8 of clear restarts it: busy=1 for 16 cycles after release.

Source files
------------

// File: rtl/param_rf_mp.sv
// Multi-port register file with registered, write-first read data and a
// built-in sequential clear engine that zeroes storage after reset or on request.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | zeroing one entry per cycle at ptr; writes blocked, q=0
// ST_IDLE  | normal read/write operation; clr starts a new clear
module param_rf_mp #(
    parameter int WIDTH     = 13,
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 7,
    parameter int NWR       = 2,
    parameter int NRD       = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NWR-1:0]           we,
    input  logic [NWR*ADDR_BITS-1:0] waddr,
    input  logic [NWR*WIDTH-1:0]     din,
    input  logic [NRD*ADDR_BITS-1:0] raddr,
    output logic [NRD*WIDTH-1:0]     q,
    input  logic                     clr,
    output logic                     busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_BITS:0] DEPTH_A  = (ADDR_BITS + 1)'(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]                  state;
    logic [PTR_W-1:0]            ptr;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [NWR-1:0]              wr_en;
    logic [NRD*WIDTH-1:0]        rd_val;
    logic [ADDR_BITS-1:0]        ra;
    logic                        load_zero;

    assign busy      = (state == ST_CLEAR);
    // q also zeroes in the cycle a clear is accepted, so no stale data escapes
    assign load_zero = busy || clr;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NWR; i++) begin
            wr_en[i] = we[i] && (state == ST_IDLE) &&
                       ({1'b0, waddr[i*ADDR_BITS +: ADDR_BITS]} < DEPTH_A);
        end
    end

    // Later ports override earlier ones, giving highest-index priority on hits.
    always_comb begin
        rd_val = '0;
        ra     = '0;
        for (int j = 0; j < NRD; j++) begin
            ra = raddr[j*ADDR_BITS +: ADDR_BITS];
            if ({1'b0, ra} < DEPTH_A) begin
                rd_val[j*WIDTH +: WIDTH] = mem[ra[PTR_W-1:0]];
            end
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (waddr[i*ADDR_BITS +: ADDR_BITS] == ra)) begin
                    rd_val[j*WIDTH +: WIDTH] = din[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Storage carries no reset; the clear engine is what makes it defined.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[ptr] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i]) begin
                    mem[waddr[i*ADDR_BITS +: PTR_W]] <= din[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (ptr == PTR_LAST) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + PTR_W'(1);
                    end
                end
                default: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= load_zero ? '0 : rd_val;
        end
    end

endmodule

// File: tb/tb_param_rf_mp.sv
// Directed bench for param_rf_mp at default parameters: vector table for the
// read/write/forwarding paths plus hand-written clear and reset sequences.
module tb_param_rf_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  we;
    logic [13:0] waddr;
    logic [25:0] din;
    logic [13:0] raddr;
    logic [25:0] q;
    logic        clr;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]  we;
        logic [6:0]  wa0, wa1;
        logic [12:0] d0, d1;
        logic [6:0]  ra0, ra1;
        logic [12:0] e0, e1;
    } vec_t;

    vec_t        tbl [12];
    logic [12:0] exp_mem [16];

    param_rf_mp dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .din     (din),
        .raddr   (raddr),
        .q       (q),
        .clr     (clr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input logic [6:0] wa0, input logic [6:0] wa1,
                         input logic [12:0] d0, input logic [12:0] d1,
                         input logic [6:0] ra0, input logic [6:0] ra1);
        we    = w;
        waddr = {wa1, wa0};
        din   = {d1, d0};
        raddr = {ra1, ra0};
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic scan(input string tag);
        for (int k = 0; k < 16; k++) begin
            drive(2'b00, 7'd0, 7'd0, 13'h0, 13'h0, 7'(k), 7'(15 - k));
            tick();
            chk($sformatf("%s_q0_a%0d", tag, k), {19'h0, q[12:0]}, {19'h0, exp_mem[k]});
            chk($sformatf("%s_q1_a%0d", tag, 15 - k), {19'h0, q[25:13]}, {19'h0, exp_mem[15 - k]});
        end
    endtask

    initial begin
        int n;
        tbl[0]  = '{2'b00, 7'd0,  7'd0,   13'h0000, 13'h0000, 7'd0,   7'd15, 13'h0000, 13'h0000};
        tbl[1]  = '{2'b01, 7'd3,  7'd0,   13'h0ABC, 13'h0000, 7'd1,   7'd1,  13'h0000, 13'h0000};
        tbl[2]  = '{2'b00, 7'd0,  7'd0,   13'h0000, 13'h0000, 7'd3,   7'd3,  13'h0ABC, 13'h0ABC};
        tbl[3]  = '{2'b01, 7'd5,  7'd0,   13'h0111, 13'h0000, 7'd5,   7'd4,  13'h0111, 13'h0000};
        tbl[4]  = '{2'b00, 7'd0,  7'd0,   13'h0000, 13'h0000, 7'd5,   7'd5,  13'h0111, 13'h0111};
        tbl[5]  = '{2'b11, 7'd7,  7'd7,   13'h0001, 13'h01FF, 7'd7,   7'd7,  13'h01FF, 13'h01FF};
        tbl[6]  = '{2'b00, 7'd0,  7'd0,   13'h0000, 13'h0000, 7'd7,   7'd3,  13'h01FF, 13'h0ABC};
        tbl[7]  = '{2'b11, 7'd16, 7'd127, 13'h1234, 13'h1234, 7'd16,  7'd0,  13'h0000, 13'h0000};
        tbl[8]  = '{2'b00, 7'd0,  7'd0,   13'h0000, 13'h0000, 7'd100, 7'd15, 13'h0000, 13'h0000};
        tbl[9]  = '{2'b00, 7'd0,  7'd0,   13'h0000, 13'h0000, 7'd15,  7'd0,  13'h0000, 13'h0000};
        tbl[10] = '{2'b11, 7'd9,  7'd10,  13'h0AAA, 13'h1555, 7'd9,   7'd10, 13'h0AAA, 13'h1555};
        tbl[11] = '{2'b01, 7'd2,  7'd0,   13'h1FFF, 13'h0000, 7'd2,   7'd9,  13'h1FFF, 13'h0AAA};

        reset_n = 1'b0;
        clr     = 1'b0;
        drive(2'b00, 7'd0, 7'd0, 13'h0, 13'h0, 7'd0, 7'd0);
        repeat (3) tick();
        chk("rst_busy", {31'h0, busy}, 32'd1);
        chk("rst_q", {6'h0, q}, 32'd0);

        reset_n = 1'b1;
        wait_idle(n);
        chk("rst_clear_len", n, 16);
        for (int k = 0; k < 16; k++) exp_mem[k] = 13'h0;
        scan("init");

        for (int v = 0; v < 12; v++) begin
            drive(tbl[v].we, tbl[v].wa0, tbl[v].wa1, tbl[v].d0, tbl[v].d1, tbl[v].ra0, tbl[v].ra1);
            tick();
            chk($sformatf("vec%0d_q0", v), {19'h0, q[12:0]},  {19'h0, tbl[v].e0});
            chk($sformatf("vec%0d_q1", v), {19'h0, q[25:13]}, {19'h0, tbl[v].e1});
        end

        exp_mem[2]  = 13'h1FFF;
        exp_mem[3]  = 13'h0ABC;
        exp_mem[5]  = 13'h0111;
        exp_mem[7]  = 13'h01FF;
        exp_mem[9]  = 13'h0AAA;
        exp_mem[10] = 13'h1555;
        scan("post");

        // Fill, clear with a one-cycle clr pulse, and try to write while busy.
        for (int k = 0; k < 16; k++) begin
            drive(2'b10, 7'd0, 7'(k), 13'h0, 13'h1000 | 13'(k), 7'd0, 7'd0);
            tick();
        end
        drive(2'b00, 7'd0, 7'd0, 13'h0, 13'h0, 7'd5, 7'd2);
        tick();
        chk("fill_q0", {19'h0, q[12:0]},  32'h1005);
        chk("fill_q1", {19'h0, q[25:13]}, 32'h1002);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", {31'h0, busy}, 32'd1);
        chk("clr_accept_q0", {19'h0, q[12:0]}, 32'd0);
        drive(2'b01, 7'd2, 7'd0, 13'h0777, 13'h0, 7'd5, 7'd2);
        tick();
        chk("busy_q0", {19'h0, q[12:0]}, 32'd0);
        chk("busy_q1", {19'h0, q[25:13]}, 32'd0);
        drive(2'b00, 7'd0, 7'd0, 13'h0, 13'h0, 7'd0, 7'd0);
        wait_idle(n);
        chk("clr_len", n + 1, 16);
        for (int k = 0; k < 16; k++) exp_mem[k] = 13'h0;
        scan("clr");

        // clr held high through the first clear cycles must not restart it.
        clr = 1'b1;
        tick();
        tick();
        tick();
        tick();
        clr = 1'b0;
        wait_idle(n);
        chk("hold_clr_len", n + 3, 16);

        // Reset asserted mid-clear restarts the full sweep.
        drive(2'b01, 7'd4, 7'd0, 13'h0444, 13'h0, 7'd4, 7'd0);
        tick();
        chk("pre_rst_fwd", {19'h0, q[12:0]}, 32'h0444);
        drive(2'b00, 7'd0, 7'd0, 13'h0, 13'h0, 7'd4, 7'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        reset_n = 1'b0;
        tick();
        tick();
        chk("midrst_busy", {31'h0, busy}, 32'd1);
        chk("midrst_q", {6'h0, q}, 32'd0);
        reset_n = 1'b1;
        wait_idle(n);
        chk("midrst_clear_len", n, 16);
        drive(2'b00, 7'd0, 7'd0, 13'h0, 13'h0, 7'd4, 7'd15);
        tick();
        chk("midrst_q0", {19'h0, q[12:0]},  32'd0);
        chk("midrst_q1", {19'h0, q[25:13]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
